// File: rtl/lcd_bus_monitor.sv
// rtl/lcd_bus_monitor.sv - passive HD44780 4/8-bit write-bus monitor with DDRAM address tracking
module lcd_bus_monitor (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rs,
  input  logic       rw,
  input  logic       d4,
  input  logic       d5,
  input  logic       d6,
  input  logic       d7,
  output logic       byte_valid,
  output logic       byte_rs,
  output logic [7:0] byte_data,
  output logic       char_valid,
  output logic [6:0] char_addr,
  output logic [7:0] char_data,
  output logic [6:0] cursor,
  output logic       disp_on,
  output logic       mode4,
  output logic       err
);

  typedef enum logic [1:0] {BOOT8 = 2'd0, HI = 2'd1, LO = 2'd2} state_t;

  state_t     state, state_n;
  logic       en_q, rs_q, rw_q;
  logic [3:0] nib_q;
  logic       stb, stb_rs;
  logic [3:0] stb_nib;
  logic [3:0] hi_nib;
  logic       hi_rs;
  logic       inc;
  logic       accept, mism, fset;
  logic [7:0] acc_byte;

  // Falling edge of en is captured into a one-cycle strobe register; the
  // byte assembly below then acts on it one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      nib_q   <= 4'h0;
      stb     <= 1'b0;
      stb_rs  <= 1'b0;
      stb_nib <= 4'h0;
    end else begin
      en_q    <= en;
      rs_q    <= rs;
      rw_q    <= rw;
      nib_q   <= {d7, d6, d5, d4};
      stb     <= en_q & ~en & ~rw_q;
      stb_rs  <= rs_q;
      stb_nib <= nib_q;
    end
  end

  always_comb begin
    accept   = 1'b0;
    mism     = 1'b0;
    acc_byte = {stb_nib, 4'h0};
    if (stb) begin
      case (state)
        BOOT8: accept = 1'b1;
        LO: begin
          acc_byte = {hi_nib, stb_nib};
          if (stb_rs == hi_rs) accept = 1'b1;
          else                 mism   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fset = accept & ~stb_rs & (acc_byte[7:5] == 3'b001);

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT8;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (stb) begin
      case (state)
        BOOT8: if (fset && !acc_byte[4]) state_n = HI;
        HI:    state_n = LO;
        LO:    state_n = (fset && acc_byte[4]) ? BOOT8 : HI;
        default: state_n = BOOT8;
      endcase
    end
  end

  always_comb begin
    mode4 = (state != BOOT8);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_nib     <= 4'h0;
      hi_rs      <= 1'b0;
      byte_valid <= 1'b0;
      byte_rs    <= 1'b0;
      byte_data  <= 8'h00;
      char_valid <= 1'b0;
      char_addr  <= 7'h00;
      char_data  <= 8'h00;
      cursor     <= 7'h00;
      disp_on    <= 1'b0;
      inc        <= 1'b1;
      err        <= 1'b0;
    end else begin
      byte_valid <= accept;
      char_valid <= accept & stb_rs;
      err        <= mism;
      if (stb && state == HI) begin
        hi_nib <= stb_nib;
        hi_rs  <= stb_rs;
      end
      if (accept) begin
        byte_rs   <= stb_rs;
        byte_data <= acc_byte;
        if (stb_rs) begin
          char_addr <= cursor;
          char_data <= acc_byte;
          cursor    <= inc ? cursor + 7'd1 : cursor - 7'd1;
        end else if (acc_byte[7]) begin
          cursor <= acc_byte[6:0];
        end else if (acc_byte[6:5] == 2'b01) begin
          // function set only changes the interface mode (FSM)
        end else if (acc_byte[6:3] == 4'b0001) begin
          disp_on <= acc_byte[2];
        end else if (acc_byte[6:2] == 5'b00001) begin
          inc <= acc_byte[1];
        end else if (acc_byte[6:1] == 6'b000001) begin
          cursor <= 7'h00;
        end else if (acc_byte[6:0] == 7'h01) begin
          cursor <= 7'h00;
          inc    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/lcd_bus_monitor.md
# lcd_bus_monitor

Passive receiver for the HD44780 4-bit write bus driven by the LCD controller. It samples `en`/`rs`/`rw`/`d4..d7` in the same `clk` domain and reassembles nibbles into bytes. It tracks the 8-bit/4-bit interface mode and decodes the command subset the controller uses. It reports each written character with its DDRAM address, for on-chip mirroring (e.g. serial echo) and for self-checking benches of the LCD driver.

## Interface
- No parameters.
- `clk` input 1: system clock; all bus inputs are synchronous to it.
- `rst` input 1: synchronous, active-high reset.
- `en`, `rs`, `rw` input 1 each: LCD bus strobe, register select, read/write.
- `d4`, `d5`, `d6`, `d7` input 1 each: LCD data nibble; `d7` is the MSB.
- `byte_valid` output 1: one-cycle pulse when a complete byte is accepted.
- `byte_rs` output 1: RS of the accepted byte.
- `byte_data` output 8: accepted byte.
- `char_valid` output 1: one-cycle pulse when a data byte (RS=1) is written.
- `char_addr` output 7: DDRAM address written; this is the cursor value before the update.
- `char_data` output 8: character code.
- `cursor` output 7: current DDRAM address counter.
- `disp_on` output 1: display-on bit (D) from the last display-control command.
- `mode4` output 1: 1 when the interface is in 4-bit mode.
- `err` output 1: one-cycle pulse on an RS mismatch between the two nibbles of a byte.

## Operation
- Input stage: `en`, `rs`, `rw` and the nibble are registered every cycle into `en_q`, `rs_q`, `rw_q`, `nib_q`.
- Strobe: `en_q`=1 and `en`=0. The strobe captures `rs_q` and `nib_q`.
- Strobes with `rw_q`=1 are read cycles. They are ignored entirely; the nibble phase is unchanged.
- States:
  - BOOT8: reset state, 8-bit mode, `mode4`=0. Each strobe forms the byte `{nib_q,4'h0}` and is accepted immediately.
  - HI: 4-bit mode, waiting for the high nibble. A strobe stores the nibble and RS, then goes to LO.
  - LO: a strobe forms `{hi,nib_q}`.
    - If RS equals the stored RS: accept the byte, go to HI.
    - If RS differs: discard both nibbles, pulse `err`, go to HI.
- Decode of an accepted byte with RS=0, in priority order:
  - 1xxxxxxx: `cursor` ← byte[6:0].
  - 001Dxxxx (function set):
    - D=0: enter HI (from BOOT8 or 4-bit mode).
    - D=1: enter BOOT8.
  - 00001Dxx: `disp_on` ← D.
  - 000001Ix: increment flag ← I (1 = increment).
  - 0000001x: `cursor` ← 0.
  - 00000001: `cursor` ← 0; increment flag ← 1.
  - All other RS=0 bytes (CGRAM address, shift) are accepted but have no effect.
- Accepted byte with RS=1:
  - Pulse `char_valid` with `char_addr` = `cursor` and `char_data` = byte.
  - `cursor` ← `cursor`+1 when increment flag=1, otherwise `cursor`−1; 7-bit modulo (127→0, 0→127).
- A function set received in BOOT8 is itself accepted as a byte (`byte_valid` pulses).

## Timing
- Reset values:
  - `byte_valid`, `char_valid`, `err` = 0.
  - `byte_rs` = 0; `byte_data`, `char_data` = 0; `char_addr`, `cursor` = 0.
  - `disp_on` = 0; `mode4` = 0.
  - Increment flag = 1; state BOOT8; `en_q` = 0.
- Latency: for `en` first sampled low at edge t, the following outputs update at edge t+1:
  - `byte_valid`, `char_valid`, `err`;
  - `cursor`, `disp_on`, `mode4`.
- Pulses are exactly one cycle wide. Minimum strobe spacing is 2 cycles: `en` high for at least 1 sampled cycle, then low.
- `rst` asserted mid-byte discards a stored high nibble; `rst` overrides a simultaneous strobe.
- `en` held high indefinitely produces no strobe. Nibble and RS changes while `en` is high are tracked; the last sampled value wins.

## Test plan
- Reset, then drive 0x2 (8-bit mode) → `byte_valid` pulses with `byte_data`=0x20 and `mode4`=1. Then drive 0x2, 0xC → byte 0x2C accepted, `mode4` stays 1.
- Drive the full controller init sequence (0x0C, 0x01, 0x06) followed by "Hello World!" → `disp_on`=1; 12 `char_valid` pulses at addresses 0..11 with codes 0x48…0x21; final `cursor`=12.
- Set DDRAM address 0xFF (`cursor`=127), write 'A' → `char_addr`=127, `cursor`=0. Then entry mode 0x04, write 'B' → `char_addr`=0, `cursor`=127.
- High nibble with RS=1, low nibble with RS=0 → `err` pulses once, no `byte_valid`. The next two clean nibbles form a correct byte.
- Interleave `rw`=1 strobes between nibbles, and assert `rst` after a lone high nibble → read strobes are ignored; after reset, `mode4`=0 and the next strobe is treated as 8-bit.
